// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: writeback, held redirect with handshake, FWFT training FIFO.
// Optional performance counters are enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int ROB_W     = 6,
    parameter int PREG_W    = 6,
    parameter int UPD_DEPTH = 4
) (
    input  logic              cpu_clock_i,
    input  logic              cpu_reset_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [XLEN-1:0]   operand_1_i,
    input  logic [XLEN-1:0]   operand_2_i,
    input  logic [XLEN-1:0]   offset_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              lui_i,
    input  logic              auipc_i,
    input  logic              jal_i,
    input  logic              jalr_i,
    input  logic [2:0]        bnch_cond_i,
    input  logic [ROB_W-1:0]  rob_id_i,
    input  logic [ROB_W-1:0]  rob_head_i,
    input  logic [PREG_W-1:0] dest_i,
    input  logic [1:0]        bm_pred_i,
    input  logic [1:0]        btype_i,
    input  logic              btb_vld_i,
    input  logic [XLEN-1:0]   btb_target_i,
    input  logic              btb_way_i,
    output logic [XLEN-1:0]   result_o,
    output logic              wb_valid_o,
    output logic [PREG_W-1:0] wb_dest_o,
    output logic              res_valid_o,
    output logic [ROB_W-1:0]  rob_o,
    output logic              redir_valid_o,
    input  logic              redir_ready_i,
    output logic [XLEN-1:0]   redir_pc_o,
    output logic [ROB_W-1:0]  redir_rob_o,
    output logic              redir_misalign_o,
    output logic              upd_valid_o,
    input  logic              upd_ready_i,
    output logic [XLEN-1:0]   upd_pc_o,
    output logic [XLEN-1:0]   upd_target_o,
    output logic [1:0]        upd_cntr_o,
    output logic              upd_tkn_o,
    output logic [1:0]        upd_type_o,
    output logic              upd_way_o,
    output logic              upd_hit_o,
    output logic              upd_inval_o
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_branch_o,
    output logic [31:0]       perf_mispred_o,
    output logic [31:0]       perf_drop_o
`endif
);
    localparam int AW = $clog2(UPD_DEPTH);
    localparam int UW = 2 * XLEN + 8;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);
    localparam logic [AW:0]     PTR_ONE = (AW + 1)'(1'b1);

    logic            issue_s, is_cond_s, eq_s, lt_s, cmp_s, act_tkn_s, pred_tkn_s, mispred_s;
    logic            handoff_s, older_s, load_s;
    logic            empty_s, full_s, push_s, pop_s, push_ok_s;
    logic [XLEN-1:0] pc_inc_s, br_tgt_s, jalr_sum_s, act_tgt_s, act_npc_s, pred_npc_s, wb_data_s;
    logic [ROB_W-1:0] new_age_s, held_age_s;
    logic [UW-1:0]   entry_s;

    logic [UW-1:0]   mem_r [UPD_DEPTH];
    logic [AW:0]     wr_ptr_r, rd_ptr_r;

    // Resolve the instruction: compare, actual/predicted next PC, redirect and FIFO control.
    always_comb begin
        issue_s    = valid_i && !flush_i;
        is_cond_s  = !(lui_i || auipc_i || jal_i || jalr_i);
        pc_inc_s   = pc_i + PC_STEP;
        br_tgt_s   = pc_i + offset_i;
        jalr_sum_s = operand_1_i + offset_i;
        eq_s       = (operand_1_i == operand_2_i);
        if (bnch_cond_i[1]) begin
            lt_s = (operand_1_i < operand_2_i);
        end else begin
            lt_s = ($signed(operand_1_i) < $signed(operand_2_i));
        end
        case ({bnch_cond_i[2], bnch_cond_i[0]})
            2'b00:   cmp_s = eq_s;
            2'b01:   cmp_s = !eq_s;
            2'b10:   cmp_s = lt_s;
            2'b11:   cmp_s = !lt_s;
            default: cmp_s = 1'b0;
        endcase
        act_tkn_s = jal_i || jalr_i || (is_cond_s && cmp_s);
        if (jalr_i) begin
            act_tgt_s = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
            act_tgt_s = br_tgt_s;
        end
        if (act_tkn_s) begin
            act_npc_s = act_tgt_s;
        end else begin
            act_npc_s = pc_inc_s;
        end
        pred_tkn_s = btb_vld_i && ((btype_i == 2'b10) || bm_pred_i[1]);
        if (pred_tkn_s) begin
            pred_npc_s = btb_target_i;
        end else begin
            pred_npc_s = pc_inc_s;
        end
        mispred_s = issue_s && (pred_npc_s != act_npc_s);
        if (lui_i) begin
            wb_data_s = offset_i;
        end else if (auipc_i) begin
            wb_data_s = br_tgt_s;
        end else begin
            wb_data_s = pc_inc_s;
        end
        // Ages are distances from the ROB head, so wraparound of ids is harmless.
        new_age_s  = rob_id_i - rob_head_i;
        held_age_s = redir_rob_o - rob_head_i;
        older_s    = (new_age_s < held_age_s);
        handoff_s  = redir_valid_o && redir_ready_i;
        load_s     = mispred_s && (!redir_valid_o || handoff_s || older_s);
        empty_s    = (wr_ptr_r == rd_ptr_r);
        full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s      = !empty_s && upd_ready_i;
        push_s     = issue_s && (is_cond_s || jal_i || jalr_i || ((lui_i || auipc_i) && btb_vld_i));
        push_ok_s  = push_s && (!full_s || pop_s);
        entry_s    = {pc_i, act_tgt_s, bm_pred_i, act_tkn_s,
                      ((jal_i || jalr_i) ? 2'b10 : 2'b00), btb_way_i, btb_vld_i, (lui_i || auipc_i)};
    end

    // Writeback and ROB completion register.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            res_valid_o <= 1'b0;
            wb_valid_o  <= 1'b0;
            result_o    <= {XLEN{1'b0}};
            wb_dest_o   <= {PREG_W{1'b0}};
            rob_o       <= {ROB_W{1'b0}};
        end else begin
            res_valid_o <= issue_s;
            wb_valid_o  <= issue_s && !is_cond_s && (dest_i != {PREG_W{1'b0}});
            if (issue_s) begin
                result_o  <= wb_data_s;
                wb_dest_o <= dest_i;
                rob_o     <= rob_id_i;
            end
        end
    end

    // Single-entry redirect holding the oldest outstanding mispredict.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            redir_valid_o    <= 1'b0;
            redir_pc_o       <= {XLEN{1'b0}};
            redir_rob_o      <= {ROB_W{1'b0}};
            redir_misalign_o <= 1'b0;
        end else if (flush_i) begin
            redir_valid_o <= 1'b0;
        end else if (load_s) begin
            redir_valid_o    <= 1'b1;
            redir_pc_o       <= act_npc_s;
            redir_rob_o      <= rob_id_i;
            redir_misalign_o <= (act_npc_s[1:0] != 2'b00);
        end else if (handoff_s) begin
            redir_valid_o <= 1'b0;
        end
    end

    // Training FIFO storage and pointers; flush deliberately leaves it intact.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem_r[i] <= {UW{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign upd_valid_o = !empty_s;
    assign {upd_pc_o, upd_target_o, upd_cntr_o, upd_tkn_o,
            upd_type_o, upd_way_o, upd_hit_o, upd_inval_o} = mem_r[rd_ptr_r[AW-1:0]];

`ifdef BRU_PERF_CNT_EN
    // Free-running event counters, cleared only by reset.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            perf_branch_o  <= 32'd0;
            perf_mispred_o <= 32'd0;
            perf_drop_o    <= 32'd0;
        end else begin
            if (issue_s && (is_cond_s || jal_i || jalr_i)) begin
                perf_branch_o <= perf_branch_o + 32'd1;
            end
            if (mispred_s) begin
                perf_mispred_o <= perf_mispred_o + 32'd1;
            end
            if (push_s && !push_ok_s) begin
                perf_drop_o <= perf_drop_o + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: reference model pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        cpu_reset_i, flush_i, valid_i;
    logic [31:0] operand_1_i, operand_2_i, offset_i, pc_i;
    logic        lui_i, auipc_i, jal_i, jalr_i;
    logic [2:0]  bnch_cond_i;
    logic [5:0]  rob_id_i, rob_head_i, dest_i;
    logic [1:0]  bm_pred_i, btype_i;
    logic        btb_vld_i, btb_way_i;
    logic [31:0] btb_target_i;
    logic [31:0] result_o;
    logic        wb_valid_o, res_valid_o;
    logic [5:0]  wb_dest_o, rob_o, redir_rob_o;
    logic        redir_valid_o, redir_ready_i, redir_misalign_o;
    logic [31:0] redir_pc_o;
    logic        upd_valid_o, upd_ready_i;
    logic [31:0] upd_pc_o, upd_target_o;
    logic [1:0]  upd_cntr_o, upd_type_o;
    logic        upd_tkn_o, upd_way_o, upd_hit_o, upd_inval_o;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branch_o, perf_mispred_o, perf_drop_o;
`endif

    branch_resolve_unit #(.XLEN(32), .ROB_W(6), .PREG_W(6), .UPD_DEPTH(DEPTH)) dut (
        .cpu_clock_i(clk), .cpu_reset_i(cpu_reset_i), .flush_i(flush_i), .valid_i(valid_i),
        .operand_1_i(operand_1_i), .operand_2_i(operand_2_i), .offset_i(offset_i), .pc_i(pc_i),
        .lui_i(lui_i), .auipc_i(auipc_i), .jal_i(jal_i), .jalr_i(jalr_i),
        .bnch_cond_i(bnch_cond_i), .rob_id_i(rob_id_i), .rob_head_i(rob_head_i), .dest_i(dest_i),
        .bm_pred_i(bm_pred_i), .btype_i(btype_i), .btb_vld_i(btb_vld_i),
        .btb_target_i(btb_target_i), .btb_way_i(btb_way_i),
        .result_o(result_o), .wb_valid_o(wb_valid_o), .wb_dest_o(wb_dest_o),
        .res_valid_o(res_valid_o), .rob_o(rob_o),
        .redir_valid_o(redir_valid_o), .redir_ready_i(redir_ready_i), .redir_pc_o(redir_pc_o),
        .redir_rob_o(redir_rob_o), .redir_misalign_o(redir_misalign_o),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_pc_o(upd_pc_o),
        .upd_target_o(upd_target_o), .upd_cntr_o(upd_cntr_o), .upd_tkn_o(upd_tkn_o),
        .upd_type_o(upd_type_o), .upd_way_o(upd_way_o), .upd_hit_o(upd_hit_o),
        .upd_inval_o(upd_inval_o)
`ifdef BRU_PERF_CNT_EN
        , .perf_branch_o(perf_branch_o), .perf_mispred_o(perf_mispred_o), .perf_drop_o(perf_drop_o)
`endif
    );

    typedef struct packed {
        logic [31:0] pc, tgt;
        logic [1:0]  cntr;
        logic        tkn;
        logic [1:0]  typ;
        logic        way, hit, inval;
    } upd_t;

    typedef struct packed {
        logic        rst, res_valid, wb_valid;
        logic [5:0]  rob, dest;
        logic [31:0] result;
        logic        redir_valid;
        logic [31:0] redir_pc;
        logic [5:0]  redir_rob;
        logic        redir_mis, upd_valid;
        upd_t        upd;
    } exp_t;

    exp_t exp_q[$];
    upd_t m_fifo[$];
    logic        m_rv, m_rmis;
    logic [31:0] m_rpc;
    logic [5:0]  m_rrob;
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Reference model: what the outputs must show after the coming clock edge.
    task automatic model_step();
        exp_t e;
        upd_t u;
        logic cond, eq, lt, cmp, atkn, ptkn, issue, pop, push, hand;
        logic [31:0] tgt, anpc, pnpc, p4;
        int na, ha;
        e = '0;
        if (cpu_reset_i) begin
            m_fifo.delete();
            m_rv = 1'b0; m_rpc = 32'd0; m_rrob = 6'd0; m_rmis = 1'b0;
            e.rst = 1'b1;
        end else begin
            issue = valid_i && !flush_i;
            cond  = !(lui_i || auipc_i || jal_i || jalr_i);
            p4    = pc_i + 32'd4;
            eq    = (operand_1_i == operand_2_i);
            lt    = bnch_cond_i[1] ? (operand_1_i < operand_2_i)
                                   : ($signed(operand_1_i) < $signed(operand_2_i));
            case (bnch_cond_i)
                3'b000, 3'b010: cmp = eq;
                3'b001, 3'b011: cmp = !eq;
                3'b100, 3'b110: cmp = lt;
                default:        cmp = !lt;
            endcase
            atkn = jal_i || jalr_i || (cond && cmp);
            tgt  = jalr_i ? ((operand_1_i + offset_i) & 32'hFFFF_FFFE) : (pc_i + offset_i);
            anpc = atkn ? tgt : p4;
            ptkn = btb_vld_i && (btype_i == 2'b10 || bm_pred_i[1]);
            pnpc = ptkn ? btb_target_i : p4;
            pop  = (m_fifo.size() > 0) && upd_ready_i;
            push = issue && (cond || jal_i || jalr_i || ((lui_i || auipc_i) && btb_vld_i));
            if (pop) void'(m_fifo.pop_front());
            if (push && m_fifo.size() < DEPTH) begin
                u.pc = pc_i; u.tgt = tgt; u.cntr = bm_pred_i; u.tkn = atkn;
                u.typ = (jal_i || jalr_i) ? 2'b10 : 2'b00;
                u.way = btb_way_i; u.hit = btb_vld_i; u.inval = lui_i || auipc_i;
                m_fifo.push_back(u);
            end
            hand = m_rv && redir_ready_i;
            na = (int'(rob_id_i) - int'(rob_head_i) + 64) % 64;
            ha = (int'(m_rrob) - int'(rob_head_i) + 64) % 64;
            if (flush_i) begin
                m_rv = 1'b0;
            end else if (issue && pnpc != anpc && (!m_rv || hand || na < ha)) begin
                m_rv = 1'b1; m_rpc = anpc; m_rrob = rob_id_i; m_rmis = (anpc[1:0] != 2'b00);
            end else if (hand) begin
                m_rv = 1'b0;
            end
            e.res_valid = issue;
            e.rob       = rob_id_i;
            e.wb_valid  = issue && !cond && dest_i != 6'd0;
            e.dest      = dest_i;
            e.result    = lui_i ? offset_i : auipc_i ? (pc_i + offset_i) : p4;
        end
        e.redir_valid = m_rv; e.redir_pc = m_rpc; e.redir_rob = m_rrob; e.redir_mis = m_rmis;
        e.upd_valid = (m_fifo.size() > 0);
        if (m_fifo.size() > 0) e.upd = m_fifo[0];
        exp_q.push_back(e);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_br(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic [31:0] off);
        valid_i = 1'b1; lui_i = 1'b0; auipc_i = 1'b0; jal_i = 1'b0; jalr_i = 1'b0;
        bnch_cond_i = fn; operand_1_i = a; operand_2_i = b; pc_i = p; offset_i = off;
        btb_vld_i = 1'b0; btype_i = 2'b00; bm_pred_i = 2'b00;
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("res_valid", res_valid_o, e.res_valid);
                check("wb_valid", wb_valid_o, e.wb_valid);
                check("redir_valid", redir_valid_o, e.redir_valid);
                check("upd_valid", upd_valid_o, e.upd_valid);
                if (e.res_valid || e.rst) begin
                    check("rob", rob_o, e.rob);
                    check("result", result_o, e.result);
                    check("wb_dest", wb_dest_o, e.dest);
                end
                if (e.redir_valid || e.rst) begin
                    check("redir_pc", redir_pc_o, e.redir_pc);
                    check("redir_rob", redir_rob_o, e.redir_rob);
                    check("redir_mis", redir_misalign_o, e.redir_mis);
                end
                if (e.upd_valid || e.rst) begin
                    check("upd_pc", upd_pc_o, e.upd.pc);
                    check("upd_tgt", upd_target_o, e.upd.tgt);
                    check("upd_cntr", upd_cntr_o, e.upd.cntr);
                    check("upd_tkn", upd_tkn_o, e.upd.tkn);
                    check("upd_type", upd_type_o, e.upd.typ);
                    check("upd_way", upd_way_o, e.upd.way);
                    check("upd_hit", upd_hit_o, e.upd.hit);
                    check("upd_inval", upd_inval_o, e.upd.inval);
                end
            end
        end
    end

    initial begin
        int sel;
        cpu_reset_i = 1'b1; flush_i = 1'b0; redir_ready_i = 1'b0; upd_ready_i = 1'b0;
        set_br(3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
        valid_i = 1'b0; rob_id_i = 6'd0; rob_head_i = 6'd0; dest_i = 6'd0;
        btb_target_i = 32'd0; btb_way_i = 1'b0;
        @(negedge clk);
        #1;
        step();
        step();
        check("reset_redir_valid", redir_valid_o, 32'd0);
        check("reset_upd_valid", upd_valid_o, 32'd0);
        check("reset_result", result_o, 32'd0);
        cpu_reset_i = 1'b0;

        // BEQ taken, no BTB hit
        set_br(3'b000, 32'd5, 32'd5, 32'h100, 32'h20); rob_id_i = 6'd1;
        step();
        check("beq_redir_valid", redir_valid_o, 32'd1);
        check("beq_redir_pc", redir_pc_o, 32'h120);
        check("beq_upd_valid", upd_valid_o, 32'd1);
        check("beq_upd_tkn", upd_tkn_o, 32'd1);
        check("beq_upd_hit", upd_hit_o, 32'd0);
        valid_i = 1'b0; redir_ready_i = 1'b1; upd_ready_i = 1'b1;
        step();
        check("drain_redir", redir_valid_o, 32'd0);

        // signed vs unsigned less-than
        set_br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        step();
        check("blt_redir_valid", redir_valid_o, 32'd1);
        check("blt_redir_pc", redir_pc_o, 32'h240);
        set_br(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40);
        step();
        check("bltu_no_redir", redir_valid_o, 32'd0);

        // oldest-mispredict selection relative to ROB head
        redir_ready_i = 1'b0; rob_head_i = 6'd60;
        set_br(3'b000, 32'd5, 32'd5, 32'h400, 32'h10); rob_id_i = 6'd2;
        step();
        check("age_first_rob", redir_rob_o, 32'd2);
        pc_i = 32'h500; rob_id_i = 6'd62;
        step();
        check("age_older_rob", redir_rob_o, 32'd62);
        check("age_older_pc", redir_pc_o, 32'h510);
        pc_i = 32'h600; rob_id_i = 6'd5;
        step();
        check("age_younger_kept", redir_rob_o, 32'd62);
        valid_i = 1'b0; redir_ready_i = 1'b1;
        step();

        // JALR to a misaligned target with link writeback
        redir_ready_i = 1'b0;
        set_br(3'b000, 32'h203, 32'd0, 32'h700, 32'd0);
        jalr_i = 1'b1; dest_i = 6'd3; rob_id_i = 6'd7; rob_head_i = 6'd7;
        step();
        check("jalr_redir_pc", redir_pc_o, 32'h202);
        check("jalr_misalign", redir_misalign_o, 32'd1);
        check("jalr_result", result_o, 32'h704);
        check("jalr_wb_valid", wb_valid_o, 32'd1);
        jalr_i = 1'b0; dest_i = 6'd0;

        // FIFO overflow drops the last update
        valid_i = 1'b0; upd_ready_i = 1'b1; redir_ready_i = 1'b1;
        repeat (DEPTH) step();
        check("fifo_empty", upd_valid_o, 32'd0);
        upd_ready_i = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            set_br(3'b000, 32'd1, 32'd2, 32'h1000 + 32'(i * 4), 32'd8);
            step();
        end
        valid_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("fifo_order", upd_pc_o, 32'h1000 + 32'(i * 4));
            upd_ready_i = 1'b1;
            step();
        end
        check("fifo_dropped", upd_valid_o, 32'd0);

        // pop on the full cycle lets the push through
        upd_ready_i = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i == DEPTH) upd_ready_i = 1'b1;
            set_br(3'b000, 32'd1, 32'd2, 32'h2000 + 32'(i * 4), 32'd8);
            step();
        end
        valid_i = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            check("fifo_popfull_order", upd_pc_o, 32'h2000 + 32'(i * 4));
            upd_ready_i = 1'b1;
            step();
        end
        check("fifo_popfull_empty", upd_valid_o, 32'd0);

        // flush kills issue and redirect but not the FIFO
        redir_ready_i = 1'b0; upd_ready_i = 1'b0;
        set_br(3'b000, 32'd5, 32'd5, 32'h3000, 32'h40); rob_id_i = 6'd9;
        step();
        check("pre_flush_redir", redir_valid_o, 32'd1);
        set_br(3'b000, 32'd5, 32'd5, 32'h3100, 32'h40); flush_i = 1'b1;
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush_redir", redir_valid_o, 32'd0);
        check("flush_res_valid", res_valid_o, 32'd0);
        check("flush_fifo_valid", upd_valid_o, 32'd1);
        check("flush_fifo_pc", upd_pc_o, 32'h3000);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 6);
            valid_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 15) == 0);
            lui_i = (sel == 3); auipc_i = (sel == 4); jal_i = (sel == 5); jalr_i = (sel == 6);
            bnch_cond_i = 3'($urandom_range(0, 7));
            operand_1_i = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            operand_2_i = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            offset_i = $urandom & 32'h0000_0FFF;
            pc_i = $urandom & 32'h000F_FFFC;
            btb_vld_i = $urandom_range(0, 1);
            btype_i = 2'($urandom_range(0, 3));
            bm_pred_i = 2'($urandom_range(0, 3));
            btb_way_i = $urandom_range(0, 1);
            btb_target_i = ($urandom_range(0, 1) != 0) ? (pc_i + offset_i) : $urandom;
            rob_id_i = 6'($urandom_range(0, 63));
            rob_head_i = 6'($urandom_range(0, 63));
            dest_i = 6'($urandom_range(0, 3));
            redir_ready_i = $urandom_range(0, 1);
            upd_ready_i = ($urandom_range(0, 2) == 0);
            step();
        end
        valid_i = 1'b0; flush_i = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the execute-stage branch unit.
- Resolves conditional branches, JAL/JALR and LUI/AUIPC; writes back link/immediate results.
- Holds the oldest outstanding mispredict in a redirect register with a valid/ready handshake to the RCU, instead of a one-cycle pulse.
- Buffers BTB/bimodal training updates in a FIFO so the front end can apply them when free.

Parameters:
- XLEN, 32, datapath and PC width
- ROB_W, 6, ROB id width; age compare is modulo 2^ROB_W
- PREG_W, 6, physical destination register width
- UPD_DEPTH, 4, training FIFO depth; power of two, at least 2

Ports:
- cpu_clock_i in 1: clock
- cpu_reset_i in 1: synchronous, active-high reset
- flush_i in 1: pipeline flush
- valid_i in 1: instruction issued this cycle
- operand_1_i, operand_2_i in XLEN: source operands
- offset_i in XLEN: immediate
- pc_i in XLEN: instruction PC
- lui_i, auipc_i, jal_i, jalr_i in 1: op class, one-hot or none (none = conditional branch)
- bnch_cond_i in 3: funct3
- rob_id_i in ROB_W: ROB id of the instruction
- rob_head_i in ROB_W: current oldest ROB id
- dest_i in PREG_W: destination register
- bm_pred_i in 2: bimodal counter value
- btype_i in 2: BTB entry type; 00 = cond, 10 = jump
- btb_vld_i in 1: BTB hit
- btb_target_i in XLEN: predicted target
- btb_way_i in 1: BTB way that hit
- result_o out XLEN, wb_valid_o out 1, wb_dest_o out PREG_W: register writeback
- res_valid_o out 1, rob_o out ROB_W: completion to ROB
- redir_valid_o out 1, redir_ready_i in 1: redirect handshake
- redir_pc_o out XLEN: correct next PC
- redir_rob_o out ROB_W: ROB id of the mispredicting instruction
- redir_misalign_o out 1: next PC has bits [1:0] non-zero; raise an exception, do not fetch
- upd_valid_o out 1, upd_ready_i in 1: training FIFO handshake
- upd_pc_o out XLEN, upd_target_o out XLEN, upd_cntr_o out 2, upd_tkn_o out 1, upd_type_o out 2, upd_way_o out 1, upd_hit_o out 1, upd_inval_o out 1: training payload

Behaviour:
- Reset: all valid outputs 0, FIFO empty, redirect register empty; data outputs 0.
- Issue qualifier: a valid issue is valid_i && !flush_i. All outputs are registered with 1-cycle latency.
- Compare and condition:
  - Compare is full XLEN. Signed/unsigned is selected by bnch_cond_i[1].
  - {bnch_cond_i[2], bnch_cond_i[0]}: 00 = EQ, 01 = NE, 10 = LT, 11 = GE.
- Taken and next PC:
  - act_tkn = jal | jalr | (cond && cmp).
  - act_tgt: jal/cond use pc+offset; jalr uses (op1+offset) & ~1.
  - act_npc = act_tkn ? act_tgt : pc+4.
- Prediction:
  - pred_tkn = btb_vld_i && (btype_i == 10 || bm_pred_i[1]).
  - pred_npc = pred_tkn ? btb_target_i : pc+4.
  - For lui/auipc, act_npc = pc+4.
- Mispredict = pred_npc != act_npc.
- Writeback:
  - result_o = lui ? offset : auipc ? pc+offset : pc+4.
  - wb_valid_o = issue && (lui|auipc|jal|jalr) && dest_i != 0.
  - res_valid_o = issue.
- Redirect register, single entry. On an issue with mispredict:
  - Register empty, or held entry handed off (valid && ready) this cycle: load the new one.
  - Otherwise replace only if the new one is older: (rob_id_i - rob_head_i) < (held - rob_head_i), modulo 2^ROB_W.
  - Equal age cannot occur.
  - Held entry stays stable until accepted. valid && ready with no new load clears it.
- flush_i clears the redirect register the same edge and overrides everything else.
- Training push, applied on an issue:
  - cond, or jal/jalr, or (lui/auipc && btb_vld_i).
  - Payload: pc, act_tgt, bm_pred_i, act_tkn, type (jal|jalr ? 10 : 00), btb_way_i, btb_vld_i, and inval = lui|auipc.
  - FIFO full at push: the update is dropped. A simultaneous pop frees the slot, so the push succeeds.
  - flush_i does not clear the FIFO.
  - Pointers wrap modulo UPD_DEPTH, with an extra bit for full/empty.
  - The FIFO is first-word-fall-through: payload is valid whenever upd_valid_o is high.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_branch_o [31:0], perf_mispred_o [31:0] and perf_drop_o [31:0].
  - Counters count issued cond/jal/jalr, issued mispredicts, and dropped training updates.
  - Counters wrap, are reset to 0, and are not affected by flush.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- BEQ op1=op2=5, pc=0x100, offset=0x20, btb_vld_i=0 -> next cycle redir_valid_o=1, redir_pc_o=0x120; one update pushed with upd_tkn_o=1 and upd_hit_o=0.
- BLT op1=0xFFFFFFFF, op2=1 (signed taken) and BLTU with the same operands (not taken) -> signed resolves taken; unsigned matches a not-taken prediction, so no redirect.
- Hold redir_ready_i=0 and rob_head_i=60; mispredict rob 2, then rob 62 -> redir_rob_o becomes 62. A later mispredict at rob 5 does not replace it.
- JALR op1=0x203, offset=0 -> redir_pc_o=0x202 with redir_misalign_o=1; with dest_i=3, result_o=pc+4 and wb_valid_o=1.
- upd_ready_i=0, push UPD_DEPTH+1 branches -> exactly UPD_DEPTH are retained in order and the last is dropped. Repeat with a simultaneous pop on the full cycle -> no drop.
- flush_i asserted with valid_i and a pending redirect -> redir_valid_o=0 and res_valid_o=0 next cycle; FIFO contents unchanged.
